// File: rtl/cyclic_lamp.sv
// Free-running RED -> GREEN -> YELLOW lamp sequencer with per-phase hold counts.
// The lamp bus is registered alongside the state so it always matches the current phase.
`timescale 1ns/1ps
module cyclic_lamp #(
  parameter int RED_CYCLES    = 4,
  parameter int GREEN_CYCLES  = 3,
  parameter int YELLOW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [0:2] light
);

  localparam int MAX_CYC =
    (RED_CYCLES > GREEN_CYCLES) ?
      ((RED_CYCLES > YELLOW_CYCLES) ? RED_CYCLES : YELLOW_CYCLES) :
      ((GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10
  } state_e;

  // Plain vector so the spare code 2'b11 stays representable and recoverable.
  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [0:2]       light_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RED;
      cnt_q   <= '0;
      light_q <= LAMP_RED;
    end else begin
      case (state_q)
        S_RED: begin
          if (cnt_q == RED_LAST) begin
            state_q <= S_GREEN;
            cnt_q   <= '0;
            light_q <= LAMP_GREEN;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            light_q <= LAMP_RED;
          end
        end
        S_GREEN: begin
          if (cnt_q == GREEN_LAST) begin
            state_q <= S_YELLOW;
            cnt_q   <= '0;
            light_q <= LAMP_YELLOW;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            light_q <= LAMP_GREEN;
          end
        end
        S_YELLOW: begin
          if (cnt_q == YELLOW_LAST) begin
            state_q <= S_RED;
            cnt_q   <= '0;
            light_q <= LAMP_RED;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            light_q <= LAMP_YELLOW;
          end
        end
        default: begin
          state_q <= S_RED;
          cnt_q   <= '0;
          light_q <= LAMP_RED;
        end
      endcase
    end
  end

  assign light = light_q;

endmodule

// File: tb/tb_cyclic_lamp.sv
// Bench for cyclic_lamp: three parameterisations run side by side against a
// position-in-period model (pos counts edges since the last reset, modulo the period).
`timescale 1ns/1ps
module tb_cyclic_lamp;

  logic       clk = 1'b0;
  logic       rst_n0, rst_n1, rst_n2;
  logic [0:2] light0, light1, light2;

  int checks = 0;
  int errors = 0;

  int pos0, pos1, pos2;
  bit vld0, vld1, vld2;
  bit ill0;

  always #5 clk = ~clk;

  cyclic_lamp u_d0 (.clk(clk), .rst_n(rst_n0), .light(light0));
  cyclic_lamp #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1))
    u_d1 (.clk(clk), .rst_n(rst_n1), .light(light1));
  cyclic_lamp #(.RED_CYCLES(7), .GREEN_CYCLES(5), .YELLOW_CYCLES(2))
    u_d2 (.clk(clk), .rst_n(rst_n2), .light(light2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [0:2] lamp(input int pos, input int r, input int g);
    if (pos < r)          return 3'b100;
    else if (pos < r + g) return 3'b010;
    else                  return 3'b001;
  endfunction

  // Advance one posedge, update the models from the sampled inputs, then compare.
  task automatic tick();
    @(posedge clk);
    if (!rst_n0 || ill0) begin pos0 = 0; vld0 = 1'b1; end
    else                 pos0 = (pos0 + 1) % 8;
    if (!rst_n1) begin pos1 = 0; vld1 = 1'b1; end
    else         pos1 = (pos1 + 1) % 3;
    if (!rst_n2) begin pos2 = 0; vld2 = 1'b1; end
    else         pos2 = (pos2 + 1) % 14;
    #1;
    if (vld0) begin
      chk("d0_light", 32'(light0), 32'(lamp(pos0, 4, 3)));
      chk("d0_onehot", 32'($onehot(light0)), 32'd1);
    end
    if (vld1) begin
      chk("d1_light", 32'(light1), 32'(lamp(pos1, 1, 1)));
      chk("d1_onehot", 32'($onehot(light1)), 32'd1);
    end
    if (vld2) begin
      chk("d2_light", 32'(light2), 32'(lamp(pos2, 7, 5)));
      chk("d2_onehot", 32'($onehot(light2)), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
    pos0 = 0; pos1 = 0; pos2 = 0;
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    ill0 = 1'b0;

    // Reset held for three edges
    repeat (3) tick();

    // Release and run three full default periods (and longer for the other instances)
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    repeat (24) tick();
    repeat (30) tick();

    // Reset pulse during the second GREEN cycle of the default instance
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pos0 == 5) found = 1'b1;
      else tick();
    end
    chk("align_green2", 32'(found), 32'd1);
    rst_n0 = 1'b0;
    tick();
    rst_n0 = 1'b1;
    repeat (12) tick();

    // Illegal state code injected while GREEN is showing
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pos0 == 4) found = 1'b1;
      else tick();
    end
    chk("align_illegal", 32'(found), 32'd1);
    force u_d0.state_q = 2'b11;
    #1;
    release u_d0.state_q;
    ill0 = 1'b1;
    tick();
    ill0 = 1'b0;
    repeat (16) tick();

    // Random reset pulses on each instance independently
    for (int i = 0; i < 400; i++) begin
      rst_n0 = ($urandom_range(0, 15) != 0);
      rst_n1 = ($urandom_range(0, 15) != 0);
      rst_n2 = ($urandom_range(0, 31) != 0);
      tick();
    end
    rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
